lfsr_seq_gen: RTL and testbench
===============================

Name: lfsr_seq_gen

Overview:
Parametrised Fibonacci LFSR sequence generator for the Simon game. It replaces the fixed 2-bit LFSR.
- Produces a pseudo-random symbol stream (colour index) of SYM_BITS bits per step.
- Holds a per-game "round seed" so the identical sequence can be replayed from step 0 each round.
- Counts steps since the last restart.
- Never enters the all-zero lock-up state.
- Sits between the game FSM (drives enable/restart/reseed) and the display/compare logic (consumes sym, step_cnt).

Parameters:
WIDTH, 8, LFSR state width; legal 3..16.
TAPS, 8'hB8, feedback mask; bit i set means q[i] is XORed into feedback. Must be non-zero with bit WIDTH-1 set.
SEED, 8'h01, power-on and lock-up recovery state; must be non-zero.
SYM_BITS, 2, symbol width; legal 1..WIDTH.
CNT_W, 6, step counter width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
enable  in  1  advance LFSR one step this cycle
restart  in  1  reload LFSR from round seed; clear step counter
reseed  in  1  capture seed_in as new round seed and load it
seed_in  in  WIDTH  new seed value, sampled when reseed=1
q  out  WIDTH  current LFSR state
sym  out  SYM_BITS  current symbol = q[SYM_BITS-1:0]
step_cnt  out  CNT_W  enable-steps since last restart/reseed/reset
step_sat  out  1  high while step_cnt is at its maximum value (all ones)

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous-to-clk release handled upstream):
  - q = SEED, round_seed = SEED
  - step_cnt = 0, step_sat = 0
  - sym = SEED[SYM_BITS-1:0]
- Feedback: fb = XOR-reduction of (q & TAPS). Next state = {q[WIDTH-2:0], fb}.
- Per-cycle priority, highest first (exactly one action per cycle):
  1. reseed=1:
     - eff = (seed_in == 0) ? SEED : seed_in
     - round_seed <= eff, q <= eff, step_cnt <= 0
     - enable and restart are ignored this cycle
  2. restart=1: q <= round_seed, step_cnt <= 0; enable ignored.
  3. enable=1:
     - q <= next state
     - step_cnt <= step_cnt+1, saturating at 2^CNT_W-1 (no wrap)
     - the LFSR keeps advancing after saturation
  4. Otherwise: hold all state.
- Lock-up guard: if q is ever all-zero at a clock edge with enable=1, the next q is SEED instead of the shift result. This is defensive; it is unreachable in legal operation.
- Latency:
  - One clock from control input to q/sym/step_cnt update.
  - sym and step_sat are combinational from registered state (no extra stage).
- step_sat = (step_cnt == all ones).
- With default TAPS (polynomial x^8+x^4+x^3+x^2+1, primitive), the sequence period is 255 and q is never 0.
- Reset asserted mid-sequence returns everything to reset values immediately, regardless of clk. round_seed is lost and reverts to SEED.
- seed_in is don't-care when reseed=0.

Decomposition:
- Shared package simon_pkg:
  - default LFSR constants (LFSR_W, LFSR_TAPS, LFSR_SEED)
  - SYM_W = 2
  - step counter width sized to the maximum game length
- Natural sub-module: lfsr_core (state register, feedback, lock-up guard, load port).
- lfsr_seq_gen wraps lfsr_core with:
  - the round-seed register
  - the control priority logic
  - the saturating step counter

Test Plan:
- Reset, then enable=1 for 5 cycles (defaults) -> q after reset 8'h01, then 02, 04, 08, 11, 23. sym = 1, 2, 0, 0, 1, 3. step_cnt = 0..5.
- enable=1 for 255 consecutive cycles from SEED -> q never 8'h00, all 255 non-zero values visited once, q back to 8'h01 at cycle 255.
- Advance 7 steps, pulse restart, advance 7 again -> second q/sym sequence identical to first. step_cnt 0 after restart, 7 at end.
- reseed with seed_in=8'h5A and enable=1 in the same cycle -> q=8'h5A, step_cnt=0, no advance that cycle. Later restart returns q to 8'h5A.
- reseed with seed_in=8'h00 -> q=8'h01 (SEED). Following steps match the first scenario.
- Advance 70 steps with CNT_W=6 -> step_cnt stops at 63, step_sat=1, q still changing. Assert reset mid-cycle -> q=8'h01, step_cnt=0, step_sat=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared constants for the Simon game datapath.
// LFSR defaults, symbol width and step counter sizing.
package simon_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h01;

    localparam int SYM_W = 2;

    // Longest game the step counter must represent.
    localparam int MAX_STEPS = 63;
    localparam int STEP_CNT_W = $clog2(MAX_STEPS + 1);

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with load port.
// A zero state is forced back to SEED on a step.
module lfsr_core
    import simon_pkg::*;
#(
    parameter int WIDTH = LFSR_W,
    parameter logic [WIDTH-1:0] TAPS = LFSR_TAPS,
    parameter logic [WIDTH-1:0] SEED = LFSR_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    logic             fb;
    logic [WIDTH-1:0] shifted;
    logic             locked;

    // Feedback and shift result for the current state.
    always_comb begin
        fb      = ^(q & TAPS);
        shifted = {q[WIDTH-2:0], fb};
        locked  = (q == '0);
    end

    // State register: load wins over step; zero state recovers to SEED.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= SEED;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= locked ? SEED : shifted;
        end
    end

endmodule

// File: rtl/lfsr_seq_gen.sv
// Simon symbol sequence generator: LFSR plus round seed,
// control priority and saturating step counter.
module lfsr_seq_gen
    import simon_pkg::*;
#(
    parameter int WIDTH = LFSR_W,
    parameter logic [WIDTH-1:0] TAPS = LFSR_TAPS,
    parameter logic [WIDTH-1:0] SEED = LFSR_SEED,
    parameter int SYM_BITS = SYM_W,
    parameter int CNT_W = STEP_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                restart,
    input  logic                reseed,
    input  logic [WIDTH-1:0]    seed_in,
    output logic [WIDTH-1:0]    q,
    output logic [SYM_BITS-1:0] sym,
    output logic [CNT_W-1:0]    step_cnt,
    output logic                step_sat
);

    logic [WIDTH-1:0] round_seed;
    logic [WIDTH-1:0] eff_seed;
    logic [WIDTH-1:0] load_val;
    logic             load;
    logic             step;

    // Control priority: reseed, then restart, then enable.
    always_comb begin
        eff_seed = (seed_in == '0) ? SEED : seed_in;
        load     = reseed | restart;
        load_val = reseed ? eff_seed : round_seed;
        step     = enable & ~load;
        sym      = q[SYM_BITS-1:0];
        step_sat = &step_cnt;
    end

    // Round seed is replaced only by reseed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            round_seed <= SEED;
        end else if (reseed) begin
            round_seed <= eff_seed;
        end
    end

    // Step counter clears on any load and saturates at all ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_cnt <= '0;
        end else if (load) begin
            step_cnt <= '0;
        end else if (step && !step_sat) begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .step     (step),
        .load     (load),
        .load_val (load_val),
        .q        (q)
    );

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// Self-checking bench for lfsr_seq_gen with default parameters.
// Vector table, directed corner sequences and a random model run.
module tb_lfsr_seq_gen;

    localparam logic [7:0] TAPS = 8'hB8;
    localparam logic [7:0] SEED = 8'h01;
    localparam int CNT_MAX = 63;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       restart;
    logic       reseed;
    logic [7:0] seed_in;
    logic [7:0] q;
    logic [1:0] sym;
    logic [5:0] step_cnt;
    logic       step_sat;

    int tests = 0;
    int fails = 0;

    // Behavioural model state.
    int m_q;
    int m_seed;
    int m_cnt;

    always #5 clk = ~clk;

    lfsr_seq_gen dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .restart  (restart),
        .reseed   (reseed),
        .seed_in  (seed_in),
        .q        (q),
        .sym      (sym),
        .step_cnt (step_cnt),
        .step_sat (step_sat)
    );

    typedef struct {
        bit       en;
        bit       rs;
        bit       rsd;
        bit [7:0] sin;
        bit [7:0] exp_q;
        int       exp_cnt;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Next LFSR state from the polynomial: parity of tapped bits
    // shifted into the bottom; a zero state recovers to SEED.
    function automatic int lfsr_next(input int s);
        int par;
        if (s == 0) return SEED;
        par = $countones(8'(s) & TAPS) % 2;
        return ((s * 2) % 256) + par;
    endfunction

    task automatic model(input bit en, input bit rs, input bit rsd,
                         input int sin);
        if (rsd) begin
            m_seed = (sin == 0) ? SEED : sin;
            m_q    = m_seed;
            m_cnt  = 0;
        end else if (rs) begin
            m_q   = m_seed;
            m_cnt = 0;
        end else if (en) begin
            m_q = lfsr_next(m_q);
            if (m_cnt < CNT_MAX) m_cnt++;
        end
    endtask

    task automatic drive(input bit en, input bit rs, input bit rsd,
                         input logic [7:0] sin);
        enable  = en;
        restart = rs;
        reseed  = rsd;
        seed_in = sin;
        @(posedge clk);
        #1;
        enable  = 1'b0;
        restart = 1'b0;
        reseed  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        @(negedge clk);
        m_q = SEED;
        m_seed = SEED;
        m_cnt = 0;
    endtask

    task automatic chk_all(input string name);
        chk({name, ".q"}, int'(q), m_q);
        chk({name, ".sym"}, int'(sym), m_q % 4);
        chk({name, ".cnt"}, int'(step_cnt), m_cnt);
        chk({name, ".sat"}, int'(step_sat), int'(m_cnt == CNT_MAX));
    endtask

    bit   seen[256];
    int   first[7];
    int   prev_q;
    int   vq;

    initial begin
        enable = 0; restart = 0; reseed = 0; seed_in = '0;
        reset = 1'b0;
        #12;

        // Table: {en, restart, reseed, seed_in, exp_q, exp_cnt}
        vecs[0]  = '{1, 0, 0, 8'h00, 8'h02, 1};
        vecs[1]  = '{1, 0, 0, 8'h00, 8'h04, 2};
        vecs[2]  = '{1, 0, 0, 8'h00, 8'h08, 3};
        vecs[3]  = '{1, 0, 0, 8'h00, 8'h11, 4};
        vecs[4]  = '{1, 0, 0, 8'h00, 8'h23, 5};
        vecs[5]  = '{0, 0, 0, 8'h77, 8'h23, 5};
        vecs[6]  = '{1, 1, 1, 8'h5A, 8'h5A, 0};
        vecs[7]  = '{1, 0, 0, 8'h00, 8'hB4, 1};
        vecs[8]  = '{1, 1, 0, 8'h00, 8'h5A, 0};
        vecs[9]  = '{1, 0, 1, 8'h00, 8'h01, 0};
        vecs[10] = '{1, 0, 0, 8'h00, 8'h02, 1};
        vecs[11] = '{1, 0, 0, 8'h00, 8'h04, 2};
        vecs[12] = '{0, 1, 0, 8'h00, 8'h01, 0};

        do_reset();
        chk("rst.q", int'(q), 8'h01);
        chk("rst.sym", int'(sym), 1);
        chk("rst.cnt", int'(step_cnt), 0);
        chk("rst.sat", int'(step_sat), 0);

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].rs, vecs[i].rsd, vecs[i].sin);
            vq = vecs[i].exp_q;
            chk($sformatf("vec%0d.q", i), int'(q), vq);
            chk($sformatf("vec%0d.sym", i), int'(sym), vq % 4);
            chk($sformatf("vec%0d.cnt", i), int'(step_cnt),
                vecs[i].exp_cnt);
        end

        // Full period from SEED visits every non-zero value once.
        do_reset();
        foreach (seen[i]) seen[i] = 1'b0;
        for (int i = 0; i < 255; i++) begin
            chk($sformatf("per%0d.nz", i), int'(q != 0), 1);
            chk($sformatf("per%0d.new", i), int'(seen[q]), 0);
            seen[q] = 1'b1;
            drive(1, 0, 0, 8'h00);
        end
        chk("per.wrap", int'(q), 8'h01);

        // Restart replays the same 7 steps.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, 0, 8'h00);
            first[i] = int'(q);
        end
        drive(0, 1, 0, 8'h00);
        chk("rep.q0", int'(q), 8'h01);
        chk("rep.cnt0", int'(step_cnt), 0);
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, 0, 8'h00);
            chk($sformatf("rep%0d.q", i), int'(q), first[i]);
        end
        chk("rep.cnt7", int'(step_cnt), 7);

        // Saturation, then asynchronous reset mid-cycle.
        do_reset();
        for (int i = 0; i < 70; i++) begin
            prev_q = int'(q);
            drive(1, 0, 0, 8'h00);
            model(1, 0, 0, 0);
        end
        chk_all("sat");
        chk("sat.flag", int'(step_sat), 1);
        chk("sat.moving", int'(q != 8'(prev_q)), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst.q", int'(q), 8'h01);
        chk("arst.cnt", int'(step_cnt), 0);
        chk("arst.sat", int'(step_sat), 0);
        reset = 1'b1;
        @(negedge clk);

        // Reset also drops the round seed.
        m_q = SEED; m_seed = SEED; m_cnt = 0;
        drive(0, 0, 1, 8'hC3);
        model(0, 0, 1, 8'hC3);
        chk_all("rs_seed");
        reset = 1'b0;
        #3;
        reset = 1'b1;
        @(negedge clk);
        drive(1, 1, 0, 8'h00);
        chk("rs_seed.lost", int'(q), 8'h01);

        // Random control against the model.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            bit en, rs, rsd;
            logic [7:0] sin;
            en  = ($urandom_range(3) != 0);
            rs  = ($urandom_range(15) == 0);
            rsd = ($urandom_range(15) == 0);
            sin = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
            drive(en, rs, rsd, sin);
            model(en, rs, rsd, int'(sin));
            chk_all($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
